geom_frame_scheduler: RTL

Per-frame sequencer for the geometry engine. On each display vsync it requests a framebuffer clear, advances the MVP frame index, launches the geometry engine, counts emitted vertices, waits for the raster side to drain, and then requests a buffer swap. It sits between display timing, the geometry engine and the framebuffer/raster logic. A watchdog prevents a hung frame from stalling the pipeline.

---
 rtl/geom_sched_pkg.sv | 24 ++
 rtl/geom_watchdog.sv | 37 +++
 rtl/geom_frame_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/geom_sched_pkg.sv
// Shared types and constants for the geometry frame scheduler.
package geom_sched_pkg;

    // Frame sequencer states; encodings are visible on the debug port.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ADVANCE = 3'd2,
        S_LAUNCH  = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5,
        S_SWAP    = 3'd6
    } state_e;

    localparam int CNT_W_DEF = 16;
    localparam int OVR_W     = 8;

    // True in the states where a frame can hang and the watchdog must run.
    function automatic logic in_watched_state(input state_e s);
        return (s == S_CLEAR) || (s == S_ADVANCE) || (s == S_LAUNCH) ||
               (s == S_RUN)   || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/geom_watchdog.sv
// Frame watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module geom_watchdog #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
    // r_count holds completed cycles, so the edge that makes it TIMEOUT_CYCLES-1
    // is the one taken while it still reads TIMEOUT_CYCLES-2.
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 2);

    logic [W-1:0] r_count;
    logic         w_at_term;

    assign w_at_term  = (r_count == TERM);
    assign o_terminal = i_enable & ~i_clear & w_at_term;

    // Cycle counter: cleared while idle, advances while a frame is in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {W{1'b0}};
        end else if (i_clear) begin
            r_count <= {W{1'b0}};
        end else if (i_enable && !w_at_term) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/geom_frame_scheduler.sv
// Per-frame sequencer: clear, advance MVP index, launch geometry, count
// vertices, wait for raster drain, then swap. Guarded by a watchdog.
module geom_frame_scheduler
    import geom_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enabled,
    input  logic             i_vsync,
    input  logic             i_clear_done,
    input  logic             i_geom_busy,
    input  logic             i_vertex_valid,
    input  logic             i_raster_idle,
    input  logic             i_clear_status,
    output logic             o_clear_req,
    output logic             o_increment_frame,
    output logic             o_geom_start,
    output logic             o_swap_buffers,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_vertex_count,
    output logic             o_timeout,
    output logic [OVR_W-1:0] o_overrun_count,
    output logic [2:0]       o_state
);

    state_e             r_state;
    logic               r_vsync_prev;
    logic               r_clear_req;
    logic               r_increment_frame;
    logic               r_geom_start;
    logic               r_swap_buffers;
    logic               r_frame_done;
    logic [CNT_W-1:0]   r_vertex_count;
    logic [CNT_W-1:0]   r_vcount;
    logic               r_timeout;
    logic [OVR_W-1:0]   r_overrun_count;

    logic w_tick;
    logic w_start;
    logic w_overrun;
    logic w_wd_enable;
    logic w_wd_clear;
    logic w_wd_terminal;

    assign w_tick      = i_vsync & ~r_vsync_prev;
    assign w_start     = w_tick & i_enabled & ~i_geom_busy & (r_state == S_IDLE);
    // Any tick that cannot start a frame is dropped and counted, except a
    // disabled idle tick with the engine free, which is simply ignored.
    assign w_overrun   = w_tick & ((r_state != S_IDLE) | i_geom_busy);
    assign w_wd_enable = in_watched_state(r_state);
    assign w_wd_clear  = (r_state == S_IDLE);

    geom_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_terminal(w_wd_terminal)
    );

    // Status registers: sticky timeout and saturating overrun count; events beat clears.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vsync_prev    <= 1'b0;
            r_timeout       <= 1'b0;
            r_overrun_count <= {OVR_W{1'b0}};
        end else begin
            r_vsync_prev <= i_vsync;
            if (w_wd_terminal) begin
                r_timeout <= 1'b1;
            end else if (i_clear_status) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
            if (w_overrun) begin
                if (r_overrun_count != {OVR_W{1'b1}}) begin
                    r_overrun_count <= r_overrun_count + {{(OVR_W-1){1'b0}}, 1'b1};
                end else begin
                    r_overrun_count <= r_overrun_count;
                end
            end else if (i_clear_status) begin
                r_overrun_count <= {OVR_W{1'b0}};
            end else begin
                r_overrun_count <= r_overrun_count;
            end
        end
    end

    // Frame FSM with registered handshake outputs; the watchdog abort overrides every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_clear_req       <= 1'b0;
            r_increment_frame <= 1'b0;
            r_geom_start      <= 1'b0;
            r_swap_buffers    <= 1'b0;
            r_frame_done      <= 1'b0;
            r_vertex_count    <= {CNT_W{1'b0}};
            r_vcount          <= {CNT_W{1'b0}};
        end else begin
            r_increment_frame <= 1'b0;
            r_swap_buffers    <= 1'b0;
            r_frame_done      <= 1'b0;
            if (w_wd_terminal) begin
                r_state      <= S_IDLE;
                r_clear_req  <= 1'b0;
                r_geom_start <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state     <= S_CLEAR;
                            r_clear_req <= 1'b1;
                            r_vcount    <= {CNT_W{1'b0}};
                        end
                    end
                    S_CLEAR: begin
                        if (i_clear_done) begin
                            r_clear_req       <= 1'b0;
                            r_increment_frame <= 1'b1;
                            r_state           <= S_ADVANCE;
                        end
                    end
                    S_ADVANCE: begin
                        r_geom_start <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                    S_LAUNCH: begin
                        if (i_geom_busy) begin
                            r_geom_start <= 1'b0;
                            r_state      <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // A strobe in the cycle busy drops still belongs to this frame.
                        if (i_vertex_valid && (r_vcount != {CNT_W{1'b1}})) begin
                            r_vcount <= r_vcount + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        if (!i_geom_busy) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (i_raster_idle) begin
                            r_swap_buffers <= 1'b1;
                            r_frame_done   <= 1'b1;
                            r_vertex_count <= r_vcount;
                            r_state        <= S_SWAP;
                        end
                    end
                    S_SWAP: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_clear_req  <= 1'b0;
                        r_geom_start <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_clear_req       = r_clear_req;
    assign o_increment_frame = r_increment_frame;
    assign o_geom_start      = r_geom_start;
    assign o_swap_buffers    = r_swap_buffers;
    assign o_frame_done      = r_frame_done;
    assign o_vertex_count    = r_vertex_count;
    assign o_timeout         = r_timeout;
    assign o_overrun_count   = r_overrun_count;
    assign o_state           = r_state;

endmodule
